result_serializer: RTL and testbench

Parallel-in, serial-out capture stage for the compressor test harness. It snapshots the compressor's flattened result columns on a capture strobe and streams them out one bit per accepted beat, LSB (dst0 bit 0) first, using a valid/ready handshake. This lets a pin-limited FPGA bench read wide multiplier results through a single data line. It is the read-side counterpart of the per-column serial-load shift registers that drive the compressor inputs.

---
 rtl/result_serializer_if.sv | 39 +++
 rtl/result_serializer.sv | 170 +++++++++++++++++
 tb/tb_result_serializer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/result_serializer_if.sv
// Capture/serial-stream bus between the compressor harness and result_serializer.
// master: harness side (drives dst/capture/dout_ready); slave: the serializer.
interface result_serializer_if #(
  parameter int unsigned NUM_COLS  = 39,
  parameter int unsigned COL_WIDTH = 1
);
  localparam int unsigned TOTAL = NUM_COLS * COL_WIDTH;

  logic [TOTAL-1:0] dst;
  logic             capture;
  logic             dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             dout_last;
  logic             busy;
  logic             overrun;

  modport master (
    output dst,
    output capture,
    output dout_ready,
    input  dout,
    input  dout_valid,
    input  dout_last,
    input  busy,
    input  overrun
  );

  modport slave (
    input  dst,
    input  capture,
    input  dout_ready,
    output dout,
    output dout_valid,
    output dout_last,
    output busy,
    output overrun
  );
endinterface

// File: rtl/result_serializer.sv
// Snapshots the flattened compressor result on capture and streams it LSB-first, one bit per beat.
// Optional trailing even-parity beat when RESULT_SERIALIZER_PARITY_EN is defined.
module result_serializer #(
  parameter int unsigned NUM_COLS  = 39,
  parameter int unsigned COL_WIDTH = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  result_serializer_if.slave  s_bus
);
  localparam int unsigned TOTAL = NUM_COLS * COL_WIDTH;
  localparam int unsigned CNT_W = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
`ifdef RESULT_SERIALIZER_PARITY_EN
    ST_PARITY = 2'd2,
`endif
    ST_SHIFT = 2'd1
  } state_t;

  state_t           r_state;
  logic [TOTAL-1:0] r_sreg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dout;
  logic             r_valid;
  logic             r_last;
  logic             r_busy;
  logic             r_overrun;

  state_t           w_state_nxt;
  logic [TOTAL-1:0] w_sreg_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_dout_nxt;
  logic             w_valid_nxt;
  logic             w_last_nxt;
  logic             w_busy_nxt;
  logic             w_overrun_nxt;
  logic             w_fire;
  logic             w_last_data;
  logic             w_frame_end;

`ifdef RESULT_SERIALIZER_PARITY_EN
  logic             r_par;
  logic             w_par_nxt;
`endif

  assign w_fire      = r_valid && s_bus.dout_ready;
  assign w_last_data = (r_cnt == CNT_W'(TOTAL - 1));

  // State and output registers; outputs are precomputed from next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_sreg    <= '0;
      r_cnt     <= '0;
      r_dout    <= 1'b0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sreg    <= w_sreg_nxt;
      r_cnt     <= w_cnt_nxt;
      r_dout    <= w_dout_nxt;
      r_valid   <= w_valid_nxt;
      r_last    <= w_last_nxt;
      r_busy    <= w_busy_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

`ifdef RESULT_SERIALIZER_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else begin
      r_par <= w_par_nxt;
    end
  end
`endif

  // Next-state, datapath and registered-output decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_sreg_nxt    = r_sreg;
    w_cnt_nxt     = r_cnt;
    w_overrun_nxt = r_overrun;
    w_frame_end   = 1'b0;
    w_dout_nxt    = 1'b0;
    w_last_nxt    = 1'b0;
`ifdef RESULT_SERIALIZER_PARITY_EN
    w_par_nxt     = r_par;
`endif

    case (r_state)
      ST_IDLE: begin
        if (s_bus.capture) begin
          w_state_nxt = ST_SHIFT;
          w_sreg_nxt  = s_bus.dst;
          w_cnt_nxt   = '0;
`ifdef RESULT_SERIALIZER_PARITY_EN
          w_par_nxt   = ^s_bus.dst;
`endif
        end
      end
      ST_SHIFT: begin
        if (w_fire) begin
          w_sreg_nxt = r_sreg >> 1;
          w_cnt_nxt  = r_cnt + CNT_W'(1);
          if (w_last_data) begin
`ifdef RESULT_SERIALIZER_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_IDLE;
            w_frame_end = 1'b1;
`endif
          end
        end
      end
`ifdef RESULT_SERIALIZER_PARITY_EN
      ST_PARITY: begin
        if (w_fire) begin
          w_state_nxt = ST_IDLE;
          w_frame_end = 1'b1;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase

    // A capture while busy is only honoured on the cycle that retires the final beat.
    if ((r_state != ST_IDLE) && s_bus.capture) begin
      if (w_frame_end) begin
        w_state_nxt = ST_SHIFT;
        w_sreg_nxt  = s_bus.dst;
        w_cnt_nxt   = '0;
`ifdef RESULT_SERIALIZER_PARITY_EN
        w_par_nxt   = ^s_bus.dst;
`endif
      end else begin
        w_overrun_nxt = 1'b1;
      end
    end

    w_valid_nxt = (w_state_nxt != ST_IDLE);
    w_busy_nxt  = (w_state_nxt != ST_IDLE);

    if (w_state_nxt == ST_SHIFT) begin
      w_dout_nxt = w_sreg_nxt[0];
`ifndef RESULT_SERIALIZER_PARITY_EN
      w_last_nxt = (w_cnt_nxt == CNT_W'(TOTAL - 1));
`endif
    end
`ifdef RESULT_SERIALIZER_PARITY_EN
    if (w_state_nxt == ST_PARITY) begin
      w_dout_nxt = w_par_nxt;
      w_last_nxt = 1'b1;
    end
`endif
  end

  assign s_bus.dout       = r_dout;
  assign s_bus.dout_valid = r_valid;
  assign s_bus.dout_last  = r_last;
  assign s_bus.busy       = r_busy;
  assign s_bus.overrun    = r_overrun;

endmodule

// File: tb/tb_result_serializer.sv
// Directed self-checking bench for result_serializer (39 x 1-bit columns).
module tb_result_serializer;
  localparam int unsigned TOTAL = 39;
`ifdef RESULT_SERIALIZER_PARITY_EN
  localparam int NBEATS = TOTAL + 1;
`else
  localparam int NBEATS = TOTAL;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  result_serializer_if #(.NUM_COLS(39), .COL_WIDTH(1)) bus ();

  result_serializer #(.NUM_COLS(39), .COL_WIDTH(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_capture(input logic [TOTAL-1:0] d);
    bus.dst     = d;
    bus.capture = 1'b1;
    tick();
    bus.capture = 1'b0;
  endtask

  // Walks a frame from beat `start`, checking every cycle; optionally captures d_next on the final beat.
  task automatic stream(input logic [TOTAL-1:0] d, input int start, input bit alt,
                        input bit cap_last, input logic [TOTAL-1:0] d_next);
    int   b   = start;
    int   cyc = 0;
    logic par = ^d;
    logic exp_bit;
    while (b < NBEATS && cyc < 400) begin
      bus.dout_ready = alt ? ((cyc % 2) == 1) : 1'b1;
      if (cap_last && (b == NBEATS - 1) && bus.dout_ready) begin
        bus.capture = 1'b1;
        bus.dst     = d_next;
      end
      exp_bit = (b < int'(TOTAL)) ? d[b] : par;
      chk($sformatf("dout_b%0d", b), 64'(bus.dout), 64'(exp_bit));
      chk($sformatf("valid_b%0d", b), 64'(bus.dout_valid), 64'(1));
      chk($sformatf("last_b%0d", b), 64'(bus.dout_last), 64'(b == NBEATS - 1));
      tick();
      bus.capture = 1'b0;
      if (bus.dout_ready) b++;
      cyc++;
    end
    chk("frame_len", 64'(cyc), alt ? 64'(2 * (NBEATS - start)) : 64'(NBEATS - start));
    bus.dout_ready = 1'b1;
  endtask

  initial begin
    logic [TOTAL-1:0] d1;

    // Reset held with activity on the inputs
    rst_n          = 1'b0;
    bus.dst        = TOTAL'({$urandom(), $urandom()});
    bus.capture    = 1'b1;
    bus.dout_ready = 1'b1;
    tick(); tick(); tick();
    chk("rst_dout",    64'(bus.dout),       64'(0));
    chk("rst_valid",   64'(bus.dout_valid), 64'(0));
    chk("rst_last",    64'(bus.dout_last),  64'(0));
    chk("rst_busy",    64'(bus.busy),       64'(0));
    chk("rst_overrun", 64'(bus.overrun),    64'(0));
    bus.capture = 1'b0;
    rst_n       = 1'b1;
    tick(); tick(); tick();
    chk("idle_valid", 64'(bus.dout_valid), 64'(0));
    chk("idle_busy",  64'(bus.busy),       64'(0));

    // Single set bit, ready held high
    do_capture(39'h1);
    stream(39'h1, 0, 1'b0, 1'b0, '0);
    chk("f1_busy_end",  64'(bus.busy),       64'(0));
    chk("f1_valid_end", 64'(bus.dout_valid), 64'(0));

    // Alternating pattern with ready toggling, starting low
    do_capture(39'h2A_AAAA_AAAA);
    stream(39'h2A_AAAA_AAAA, 0, 1'b1, 1'b0, '0);
    chk("f2_busy_end", 64'(bus.busy), 64'(0));

    // Back-to-back: capture on the final consumed beat
    do_capture(39'h40_0000_0001);
    stream(39'h40_0000_0001, 0, 1'b0, 1'b1, 39'h00_0000_0003);
    chk("b2b_busy",    64'(bus.busy),       64'(1));
    chk("b2b_valid",   64'(bus.dout_valid), 64'(1));
    chk("b2b_overrun", 64'(bus.overrun),    64'(0));
    stream(39'h00_0000_0003, 0, 1'b0, 1'b0, '0);
    chk("b2b_busy_end", 64'(bus.busy), 64'(0));

    // Capture during a frame is ignored and flags overrun
    d1 = 39'h12_3456_789A;
    do_capture(d1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("ovr_pre_b%0d", i), 64'(bus.dout), 64'(d1[i]));
      tick();
    end
    chk("ovr_b5", 64'(bus.dout), 64'(d1[5]));
    bus.dst     = 39'h7F_FFFF_FFFF;
    bus.capture = 1'b1;
    tick();
    bus.capture = 1'b0;
    chk("ovr_set", 64'(bus.overrun), 64'(1));
    stream(d1, 6, 1'b0, 1'b0, '0);
    chk("ovr_busy_end", 64'(bus.busy), 64'(0));
    tick(); tick(); tick();
    chk("ovr_sticky", 64'(bus.overrun),    64'(1));
    chk("ovr_idle",   64'(bus.dout_valid), 64'(0));

    // Reset pulse mid-frame abandons it
    d1 = 39'h7F_FFFF_FFFF;
    do_capture(d1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("rmf_b%0d", i), 64'(bus.dout), 64'(d1[i]));
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("rmf_valid",   64'(bus.dout_valid), 64'(0));
    chk("rmf_dout",    64'(bus.dout),       64'(0));
    chk("rmf_busy",    64'(bus.busy),       64'(0));
    chk("rmf_overrun", 64'(bus.overrun),    64'(0));
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rmf_post_valid%0d", i), 64'(bus.dout_valid), 64'(0));
    end
    chk("rmf_post_busy", 64'(bus.busy), 64'(0));

`ifdef RESULT_SERIALIZER_PARITY_EN
    // Parity beat: three ones -> 1, two ones -> 0
    do_capture(39'h7);
    stream(39'h7, 0, 1'b0, 1'b0, '0);
    chk("par7_busy_end", 64'(bus.busy), 64'(0));
    do_capture(39'h3);
    stream(39'h3, 0, 1'b0, 1'b0, '0);
    chk("par3_busy_end", 64'(bus.busy), 64'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
